// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan controller and its settle counter.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      EMIT   = 2'd3
   } scan_state_t;

   localparam int DEF_NUM_CH        = 4;
   localparam int DEF_SETTLE_CYCLES = 2;

   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Settle-time up-counter: cleared by i_load, advanced by i_en, o_tc flags TC_VAL.
module mux_scan_settle_cnt #(
   parameter int               CNT_W  = 4,
   parameter logic [CNT_W-1:0] TC_VAL = '0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_tc
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 mux select, samples each channel after a settle delay and
// presents the assembled word on a valid/ready handshake.
//
//   state  | meaning
//   IDLE   | waiting for start, select parked at 0
//   SETTLE | select held while the mux output settles
//   SAMPLE | capture mux output for the current select, advance or finish
//   EMIT   | word presented, waiting for the consumer
import mux_scan_pkg::*;

module mux_scan_ctrl #(
   parameter int NUM_CH        = DEF_NUM_CH,
   parameter int SEL_W         = sel_width(NUM_CH),
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CNT_W         = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              continuous,
   output logic [SEL_W-1:0]  mux_sel,
   input  logic              mux_out,
   output logic [NUM_CH-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy
);

   localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);

   scan_state_t       r_state;
   scan_state_t       w_next;
   logic [SEL_W-1:0]  r_sel;
   logic [NUM_CH-1:0] r_shadow;
   logic [NUM_CH-1:0] r_data;
   logic [NUM_CH-1:0] w_merged;
   logic              w_load;
   logic              w_en;
   logic              w_tc;

   mux_scan_settle_cnt #(
      .CNT_W  (CNT_W),
      .TC_VAL (SETTLE_TC)
   ) u_settle_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_en   (w_en),
      .o_tc   (w_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_en   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = SETTLE;
               w_load = 1'b1;
            end
         end
         SETTLE: begin
            // Counter holds at terminal count so a tight CNT_W never wraps.
            if (w_tc) begin
               w_next = SAMPLE;
            end else begin
               w_en = 1'b1;
            end
         end
         SAMPLE: begin
            if (r_sel == LAST_CH) begin
               w_next = EMIT;
            end else begin
               w_next = SETTLE;
               w_load = 1'b1;
            end
         end
         EMIT: begin
            if (sample_ready) begin
               w_next = continuous ? SETTLE : IDLE;
               w_load = continuous;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // The final channel bit goes straight into the output word alongside the shadow.
   always_comb begin
      w_merged        = r_shadow;
      w_merged[r_sel] = mux_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel    <= '0;
         r_shadow <= '0;
         r_data   <= '0;
      end else begin
         case (r_state)
            IDLE: r_sel <= '0;
            SAMPLE: begin
               r_shadow[r_sel] <= mux_out;
               if (r_sel == LAST_CH) begin
                  r_data <= w_merged;
               end else begin
                  r_sel <= r_sel + SEL_W'(1);
               end
            end
            EMIT: begin
               if (sample_ready) begin
                  r_sel <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign mux_sel      = r_sel;
   assign sample_data  = r_data;
   assign sample_valid = (r_state == EMIT);
   assign busy         = (r_state != IDLE);

endmodule
